// File: rtl/line_clear_ctrl.sv
// Row compaction sequencer for the Tetris grid: removes full rows bottom-up and zero-fills the top.
// Optional pre-clear flash of full rows is enabled by defining LCC_FLASH_EN.
module line_clear_ctrl #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CELL_W = 4
`ifdef LCC_FLASH_EN
  ,
  parameter logic [CELL_W-1:0] FLASH_COLOR  = 4'h7,
  parameter int                FLASH_CYCLES = 6250000
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared_o,
  output logic [$clog2(ROWS)-1:0]    rd_addr_o,
  input  logic [COLS*CELL_W-1:0]     rd_data_i,
  output logic                       wr_en_o,
  output logic [$clog2(ROWS)-1:0]    wr_addr_o,
  output logic [COLS*CELL_W-1:0]     wr_data_o
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS+1);
  localparam int DW = COLS*CELL_W;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    CHK,
    WR,
    FILL,
`ifdef LCC_FLASH_EN
    FLASH_RD,
    FLASH_CHK,
    FLASH_WAIT,
`endif
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   lines_q, lines_d;
  logic [DW-1:0]   row_q, row_d;
  logic            row_full;

`ifdef LCC_FLASH_EN
  localparam int TW = $clog2(FLASH_CYCLES+1);
  logic [TW-1:0]   timer_q, timer_d;
  logic            hit_q, hit_d;
`endif

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (rd_data_i[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      lines_q <= '0;
      row_q   <= '0;
`ifdef LCC_FLASH_EN
      timer_q <= '0;
      hit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      lines_q <= lines_d;
      row_q   <= row_d;
`ifdef LCC_FLASH_EN
      timer_q <= timer_d;
      hit_q   <= hit_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    count_d   = count_q;
    lines_d   = lines_q;
    row_d     = row_q;
    wr_en_o   = 1'b0;
    wr_addr_o = dst_q;
    wr_data_o = '0;
`ifdef LCC_FLASH_EN
    timer_d   = timer_q;
    hit_d     = hit_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = AW'(ROWS-1);
          dst_d   = AW'(ROWS-1);
          count_d = '0;
`ifdef LCC_FLASH_EN
          hit_d   = 1'b0;
          state_d = FLASH_RD;
`else
          state_d = RD;
`endif
        end
      end
      RD: state_d = CHK;
      CHK: begin
        if (row_full) begin
          count_d = count_q + 1'b1;
          src_d   = src_q - 1'b1;
          state_d = (src_q == '0) ? FILL : RD;
        end else if (src_q == dst_q) begin
          // Row already in its final place: skip the write.
          src_d   = src_q - 1'b1;
          dst_d   = dst_q - 1'b1;
          state_d = (src_q == '0) ? FILL : RD;
        end else begin
          row_d   = rd_data_i;
          state_d = WR;
        end
      end
      WR: begin
        wr_en_o   = 1'b1;
        wr_data_o = row_q;
        src_d     = src_q - 1'b1;
        dst_d     = dst_q - 1'b1;
        state_d   = (src_q == '0) ? FILL : RD;
      end
      FILL: begin
        // After the scan dst == count-1, so rows dst..0 are exactly the vacated rows.
        if (count_q == '0) begin
          lines_d = count_q;
          state_d = DONE;
        end else begin
          wr_en_o = 1'b1;
          if (dst_q == '0) begin
            lines_d = count_q;
            state_d = DONE;
          end else begin
            dst_d = dst_q - 1'b1;
          end
        end
      end
`ifdef LCC_FLASH_EN
      FLASH_RD: state_d = FLASH_CHK;
      FLASH_CHK: begin
        if (row_full) begin
          wr_en_o   = 1'b1;
          wr_addr_o = src_q;
          wr_data_o = {COLS{FLASH_COLOR}};
          hit_d     = 1'b1;
        end
        if (src_q == '0) begin
          src_d = AW'(ROWS-1);
          if (hit_q || row_full) begin
            timer_d = TW'(FLASH_CYCLES-1);
            state_d = FLASH_WAIT;
          end else begin
            state_d = RD;
          end
        end else begin
          src_d   = src_q - 1'b1;
          state_d = FLASH_RD;
        end
      end
      FLASH_WAIT: begin
        if (timer_q == '0) state_d = RD;
        else               timer_d = timer_q - 1'b1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o          = (state_q != IDLE) && (state_q != DONE);
  assign done_o          = (state_q == DONE);
  assign lines_cleared_o = lines_q;
  assign rd_addr_o       = src_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomized bench for line_clear_ctrl against an array-based compaction model.
module tb_line_clear_ctrl;
  localparam int ROWS = 20, COLS = 10, CELL_W = 4;
  localparam int AW = $clog2(ROWS), CW = $clog2(ROWS+1), DW = COLS*CELL_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, busy, done, wr_en;
  logic [CW-1:0] lines;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)
`ifdef LCC_FLASH_EN
    , .FLASH_COLOR(4'h7), .FLASH_CYCLES(8)
`endif
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .lines_cleared_o(lines), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data));

  logic [DW-1:0] mem [ROWS];
  logic [DW-1:0] exp_mem [ROWS];
  int exp_cnt, exp_moved;
  int checks = 0, passes = 0;
  int wr_total = 0, done_total = 0;
  int row_wr [ROWS];

  initial for (int i = 0; i < ROWS; i++) row_wr[i] = 0;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] = wr_data;
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wr_total++;
      row_wr[wr_addr]++;
    end
    if (done) done_total++;
  end

  function automatic bit is_full(logic [DW-1:0] r);
    for (int c = 0; c < COLS; c++) if (r[c*CELL_W +: CELL_W] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Survivors kept in bottom-up order, repacked against the bottom, zeros above.
  task automatic model();
    logic [DW-1:0] surv [$];
    int orig [$];
    surv.delete(); orig.delete();
    exp_cnt = 0; exp_moved = 0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (is_full(mem[r])) exp_cnt++;
      else begin surv.push_back(mem[r]); orig.push_back(r); end
    end
    for (int r = 0; r < ROWS; r++) exp_mem[r] = '0;
    foreach (surv[i]) begin
      exp_mem[ROWS-1-i] = surv[i];
      if (orig[i] != ROWS-1-i) exp_moved++;
    end
  endtask

  task automatic rand_grid(int full_pct);
    for (int r = 0; r < ROWS; r++) begin
      logic [DW-1:0] v;
      for (int c = 0; c < COLS; c++) v[c*CELL_W +: CELL_W] = CELL_W'($urandom_range(1, 15));
      if ($urandom_range(0, 99) >= full_pct) begin
        int z = $urandom_range(0, COLS-1);
        for (int c = 0; c < COLS; c++)
          if (c == z || $urandom_range(0, 2) == 0) v[c*CELL_W +: CELL_W] = '0;
      end
      mem[r] = v;
    end
  endtask

  // Starts a pass (optionally re-pulsing start mid-pass) and checks it against the model.
  task automatic run_pass(string name, int restart_at);
    int w0, d0, lat, exp_lat, bad_rows, max_w;
    int snap [ROWS];
    model();
    w0 = wr_total; d0 = done_total;
    for (int i = 0; i < ROWS; i++) snap[i] = row_wr[i];
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == restart_at) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!done) $display("FAIL %s timeout: done not seen after %0d cycles", name, lat);
    else passes++;
    checks++;
    if (lines !== CW'(exp_cnt)) $display("FAIL %s lines_cleared got %0d want %0d", name, lines, exp_cnt);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s post-done got done=%b busy=%b want 0 0", name, done, busy);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (done_total - d0 !== 1) $display("FAIL %s done pulses got %0d want 1", name, done_total - d0);
    else passes++;
    bad_rows = 0;
    for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_mem[r]) bad_rows++;
    checks++;
    if (bad_rows != 0) $display("FAIL %s grid mismatching rows got %0d want 0", name, bad_rows);
    else passes++;
`ifndef LCC_FLASH_EN
    exp_lat = 2*ROWS + exp_moved + ((exp_cnt == 0) ? 1 : exp_cnt) + 1;
    if (restart_at == 0) begin
      checks++;
      if (lat != exp_lat) $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
      else passes++;
    end
    checks++;
    if (wr_total - w0 != exp_moved + exp_cnt)
      $display("FAIL %s write count got %0d want %0d", name, wr_total - w0, exp_moved + exp_cnt);
    else passes++;
    max_w = 0;
    for (int i = 0; i < ROWS; i++) if (row_wr[i] - snap[i] > max_w) max_w = row_wr[i] - snap[i];
    checks++;
    if (max_w > 1) $display("FAIL %s max writes per row got %0d want <=1", name, max_w);
    else passes++;
`else
    exp_lat = lat;
    max_w = exp_lat;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, wr_en} !== 3'b000 || lines !== '0 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL reset got busy=%b done=%b wr_en=%b lines=%0d rd=%0d wa=%0d wd=%h want all 0",
               busy, done, wr_en, lines, rd_addr, wr_addr, wr_data);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    run_pass("empty", 0);
  endtask

  task automatic test_one_line();
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    mem[ROWS-1] = {COLS{4'h3}};
    mem[ROWS-2] = DW'(4'h1);
    run_pass("one_line", 0);
    checks++;
    if (mem[ROWS-1] !== DW'(4'h1)) $display("FAIL one_line row19 got %h want %h", mem[ROWS-1], DW'(4'h1));
    else passes++;
  endtask

  task automatic test_split_lines();
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    mem[19] = {COLS{4'h5}}; mem[17] = {COLS{4'h9}};
    mem[18] = DW'(40'h00000000A2); mem[16] = DW'(40'hB000000000);
    run_pass("split_lines", 0);
    checks++;
    if (mem[19] !== DW'(40'h00000000A2) || mem[18] !== DW'(40'hB000000000))
      $display("FAIL split_lines order got r18=%h r19=%h want B000000000 00000000a2", mem[18], mem[19]);
    else passes++;
  endtask

  task automatic test_all_full();
    for (int r = 0; r < ROWS; r++) mem[r] = {COLS{4'hF}} ^ DW'(r);
    run_pass("all_full", 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      rand_grid(20 + 8*k);
      run_pass($sformatf("random%0d", k), 0);
    end
  endtask

  task automatic test_back_to_back_start();
    rand_grid(40);
    run_pass("restart_ignored", 15);
  endtask

  task automatic test_reset_mid_pass();
    for (int r = 0; r < ROWS; r++) mem[r] = {COLS{4'h2}};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid_pass got busy=%b wr_en=%b done=%b want 0 0 0", busy, wr_en, done);
    else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef LCC_FLASH_EN
  task automatic test_flash();
    int t, gap;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    mem[ROWS-1] = {COLS{4'h4}};
    mem[0] = DW'(4'h6);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (mem[ROWS-1] !== {COLS{4'h7}} && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (mem[ROWS-1] !== {COLS{4'h7}}) $display("FAIL flash color got %h want all 7", mem[ROWS-1]);
    else passes++;
    gap = 0;
    while (!wr_en && gap < 500) begin @(negedge clk); gap++; end
    checks++;
    if (gap < 2*(ROWS-1) + 8) $display("FAIL flash hold gap got %0d want >= %0d", gap, 2*(ROWS-1) + 8);
    else passes++;
    t = 0;
    while (!done && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (lines !== CW'(1) || mem[ROWS-1] !== DW'(4'h6) || mem[0] !== '0)
      $display("FAIL flash result got lines=%0d r19=%h r0=%h want 1 6 0", lines, mem[ROWS-1], mem[0]);
    else passes++;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    test_reset();
    test_empty();
    test_one_line();
    test_split_lines();
    test_all_full();
    test_random();
    test_back_to_back_start();
    test_reset_mid_pass();
`ifdef LCC_FLASH_EN
    test_flash();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
